// File: rtl/next_pc_fetch.sv
// Fetch/PC unit of the multi-cycle core: owns the architectural PC, fetches one
// instruction per commit over a valid/ready channel and holds it for decode.
module next_pc_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_a_sel,
    input  logic            pc_b_sel,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            commit,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    output logic            resp_ready,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            fetch_err
);

    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    // Next PC: wrap-around add; register-based targets drop bit 0 (JALR rule).
    function automatic logic [XLEN-1:0] calc_next_pc(
        input logic            a_sel,
        input logic            b_sel,
        input logic [XLEN-1:0] cur_pc,
        input logic [XLEN-1:0] offs,
        input logic [XLEN-1:0] rs1
    );
        logic [XLEN-1:0] base_v;
        logic [XLEN-1:0] step_v;
        logic [XLEN-1:0] sum_v;
        base_v = b_sel ? rs1 : cur_pc;
        step_v = a_sel ? offs : PC_STEP;
        sum_v  = base_v + step_v;
        if (b_sel) begin
            sum_v[0] = 1'b0;
        end else begin
            sum_v[0] = sum_v[0];
        end
        return sum_v;
    endfunction

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic            r_req_valid;
    logic            r_resp_ready;
    logic            r_inst_valid;
    logic            r_fetch_err;

    logic [2:0]      w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_inst_nxt;
    logic [XLEN-1:0] w_next_pc;

    // Next-state, PC and instruction-latch logic.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_next_pc   = calc_next_pc(pc_a_sel, pc_b_sel, r_pc, imm, rs1_data);
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (req_ready) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (resp_valid) begin
                    w_inst_nxt  = resp_data;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_HOLD: begin
                // A misaligned target parks the unit without moving the PC.
                if (commit && (w_next_pc[1:0] != 2'b00)) begin
                    w_state_nxt = S_ERR;
                end else if (commit) begin
                    w_pc_nxt    = w_next_pc;
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_ERR;
            end
        endcase
    end

    // State registers; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_inst_valid <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_req_valid  <= (w_state_nxt == S_REQ);
            r_resp_ready <= (w_state_nxt == S_WAIT);
            r_inst_valid <= (w_state_nxt == S_HOLD);
            r_fetch_err  <= (w_state_nxt == S_ERR);
        end
    end

    assign req_valid  = r_req_valid;
    assign resp_ready = r_resp_ready;
    assign inst_valid = r_inst_valid;
    assign fetch_err  = r_fetch_err;
    assign req_addr   = r_pc;
    assign pc         = r_pc;
    assign inst       = r_inst;

endmodule
